// File: rtl/au_pipe.sv
// EX-stage address/CSR unit: next-PC with branch compare, load/store/AMO address or new CSR
// value, and exception flags, computed over an IDLE -> OPND -> SUM -> HOLD handshaked pipeline.
module au_pipe #(
   parameter int XLEN = 32,
   parameter int IALIGN = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      op,
   input  logic [2:0]      funct3,
   input  logic [4:0]      rs1_index,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   input  logic [XLEN-1:0] csr,
   input  logic [11:0]     imm12,
   input  logic [19:0]     imm20,
   input  logic [XLEN-1:0] pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] pc_next,
   output logic            redirect,
   output logic [XLEN-1:0] addr_csr,
   output logic            csr_we,
   output logic            exc_imis,
   output logic            exc_lsmis,
   output logic            exc_ill
);

   // Handshake: an op is taken on a clock edge where in_valid && in_ready; a result is
   // consumed on an edge where out_valid && out_ready && !flush. flush overrides both.
   typedef enum logic [1:0] {IDLE, OPND, SUM, HOLD} state_t;

   localparam logic [2:0] OP_SEQ = 3'd0, OP_JAL = 3'd1, OP_JALR = 3'd2, OP_BRANCH = 3'd3,
                          OP_MEM = 3'd4, OP_AMO = 3'd5, OP_CSR = 3'd6, OP_RSVD = 3'd7;

   state_t state;

   logic [2:0]      l_op, l_f3;
   logic [4:0]      l_idx;
   logic [XLEN-1:0] l_rs1, l_rs2, l_csr, l_pc;
   logic [11:0]     l_imm12;
   logic [19:0]     l_imm20;

   logic [XLEN-1:0] opa, opb;
   logic            taken;

   logic [XLEN-1:0] imm_i, imm_b, imm_j;
   logic [XLEN-1:0] n_opa, n_opb;
   logic            n_taken;

   always_comb begin
      imm_i = {{(XLEN-12){l_imm12[11]}}, l_imm12};
      imm_b = {{(XLEN-13){l_imm12[11]}}, l_imm12, 1'b0};
      imm_j = {{(XLEN-21){l_imm20[19]}}, l_imm20, 1'b0};
      n_opa = l_pc;
      n_opb = XLEN'(4);
      case (l_op)
         OP_JAL:         n_opb = imm_j;
         OP_JALR, OP_MEM: begin n_opa = l_rs1; n_opb = imm_i; end
         OP_BRANCH:      n_opb = imm_b;
         default:        ;
      endcase
      case (l_f3)
         3'b000:  n_taken = (l_rs1 == l_rs2);
         3'b001:  n_taken = (l_rs1 != l_rs2);
         3'b100:  n_taken = ($signed(l_rs1) < $signed(l_rs2));
         3'b101:  n_taken = ($signed(l_rs1) >= $signed(l_rs2));
         3'b110:  n_taken = (l_rs1 < l_rs2);
         3'b111:  n_taken = (l_rs1 >= l_rs2);
         default: n_taken = 1'b0;
      endcase
   end

   // One shared adder serves jump/branch targets and the MEM effective address.
   logic [XLEN-1:0] sum, target, seq_pc, zimm;
   logic [XLEN-1:0] r_pc_next, r_addr;
   logic            r_ill, r_redirect, r_imis, r_lsmis, r_we;

   always_comb begin
      sum    = opa + opb;
      target = (l_op == OP_JALR) ? {sum[XLEN-1:1], 1'b0} : sum;
      seq_pc = l_pc + XLEN'(4);
      zimm   = {{(XLEN-5){1'b0}}, l_idx};

      r_ill = (l_op == OP_RSVD)
           || (l_op == OP_BRANCH && l_f3[2:1] == 2'b01)
           || (l_op == OP_MEM && l_f3[1:0] == 2'b11)
           || (l_op == OP_CSR && l_f3[1:0] == 2'b00);

      r_redirect = !r_ill && (l_op == OP_JAL || l_op == OP_JALR || (l_op == OP_BRANCH && taken));
      r_pc_next  = r_redirect ? target : seq_pc;
      r_imis     = r_redirect && ((IALIGN == 32) ? (target[1:0] != 2'b00) : target[0]);

      r_addr  = '0;
      r_we    = 1'b0;
      r_lsmis = 1'b0;
      if (!r_ill) begin
         case (l_op)
            OP_MEM: begin
               r_addr = sum;
               case (l_f3[1:0])
                  2'b01:   r_lsmis = sum[0];
                  2'b10:   r_lsmis = (sum[1:0] != 2'b00);
                  default: r_lsmis = 1'b0;
               endcase
            end
            OP_AMO: begin
               r_addr  = l_rs1;
               r_lsmis = (l_rs1[1:0] != 2'b00);
            end
            OP_CSR: begin
               case (l_f3)
                  3'b001:  r_addr = l_rs1;
                  3'b010:  r_addr = l_csr | l_rs1;
                  3'b011:  r_addr = l_csr & ~l_rs1;
                  3'b101:  r_addr = zimm;
                  3'b110:  r_addr = l_csr | zimm;
                  3'b111:  r_addr = l_csr & ~zimm;
                  default: r_addr = '0;
               endcase
               r_we = (l_f3[1:0] == 2'b01) || (l_idx != 5'd0);
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         pc_next   <= RESET_PC;
         addr_csr  <= '0;
         redirect  <= 1'b0;
         csr_we    <= 1'b0;
         exc_imis  <= 1'b0;
         exc_lsmis <= 1'b0;
         exc_ill   <= 1'b0;
      end else if (flush) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  l_op     <= op;
                  l_f3     <= funct3;
                  l_idx    <= rs1_index;
                  l_rs1    <= rs1;
                  l_rs2    <= rs2;
                  l_csr    <= csr;
                  l_imm12  <= imm12;
                  l_imm20  <= imm20;
                  l_pc     <= pc;
                  in_ready <= 1'b0;
                  state    <= OPND;
               end
            end
            OPND: begin
               opa   <= n_opa;
               opb   <= n_opb;
               taken <= n_taken;
               state <= SUM;
            end
            SUM: begin
               pc_next   <= r_pc_next;
               addr_csr  <= r_addr;
               redirect  <= r_redirect;
               csr_we    <= r_we;
               exc_imis  <= r_imis;
               exc_lsmis <= r_lsmis;
               exc_ill   <= r_ill;
               out_valid <= 1'b1;
               state     <= HOLD;
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_au_pipe.sv
// Directed bench for au_pipe: hand-computed expectations queued on issue, compared by a
// monitor on each consumed result, plus latency, back-pressure and flush checks.
module tb_au_pipe;
   localparam int W = 69;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
   logic [2:0]  op, funct3;
   logic [4:0]  rs1_index;
   logic [31:0] rs1, rs2, csr, pc, pc_next, addr_csr;
   logic [11:0] imm12;
   logic [19:0] imm20;
   logic        redirect, csr_we, exc_imis, exc_lsmis, exc_ill;
   logic [W-1:0] obs;

   always #5 clk = ~clk;

   au_pipe #(.XLEN(32), .IALIGN(32), .RESET_PC(32'h0)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .funct3(funct3), .rs1_index(rs1_index), .rs1(rs1), .rs2(rs2), .csr(csr),
      .imm12(imm12), .imm20(imm20), .pc(pc), .out_valid(out_valid), .out_ready(out_ready),
      .pc_next(pc_next), .redirect(redirect), .addr_csr(addr_csr), .csr_we(csr_we),
      .exc_imis(exc_imis), .exc_lsmis(exc_lsmis), .exc_ill(exc_ill)
   );

   assign obs = {pc_next, addr_csr, redirect, csr_we, exc_imis, exc_lsmis, exc_ill};

   logic [W-1:0] exp_q[$];
   string        name_q[$];
   int           n_cmp = 0;
   int           n_bad = 0;

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Monitor: every consumed result must match the oldest queued expectation.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready && !flush) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_output: got %h expected none", obs);
         end else begin
            chk(name_q.pop_front(), obs, exp_q.pop_front());
         end
      end
   end

   // Flags order: {redirect, csr_we, exc_imis, exc_lsmis, exc_ill}
   task automatic send(input string nm, input logic [2:0] o, input logic [2:0] f,
                       input logic [4:0] idx, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [11:0] i12, input logic [19:0] i20,
                       input logic [31:0] p, input logic [31:0] e_pc, input logic [31:0] e_addr,
                       input logic [4:0] e_fl, input bit push);
      bit ok = 0;
      @(posedge clk); #1;
      op = o; funct3 = f; rs1_index = idx; rs1 = a; rs2 = b; csr = c;
      imm12 = i12; imm20 = i20; pc = p; in_valid = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1; break; end
      end
      if (!ok) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s_accept_timeout: got in_ready=0 expected 1", nm);
         in_valid = 1'b0;
         return;
      end
      if (push) begin
         exp_q.push_back({e_pc, e_addr, e_fl});
         name_q.push_back(nm);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 60; k++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      op = '0; funct3 = '0; rs1_index = '0; rs1 = '0; rs2 = '0; csr = '0;
      imm12 = '0; imm20 = '0; pc = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_in_ready", W'(in_ready), W'(1));
      chk("reset_out_valid", W'(out_valid), W'(0));
      chk("reset_outputs", obs, '0);

      // Latency: result appears on the third cycle after the accepting edge.
      send("bltu_taken", 3'd3, 3'b110, 5'd1, 32'h1, 32'hFFFF_FFFF, 32'h0, 12'h008, 20'h0,
           32'h100, 32'h110, 32'h0, 5'b10000, 1);
      @(negedge clk); chk("lat_opnd_valid", W'(out_valid), W'(0));
      @(negedge clk); chk("lat_sum_valid", W'(out_valid), W'(0));
      @(negedge clk); chk("lat_hold_valid", W'(out_valid), W'(1));

      send("blt_not_taken", 3'd3, 3'b100, 5'd1, 32'h1, 32'hFFFF_FFFF, 32'h0, 12'h008, 20'h0,
           32'h100, 32'h104, 32'h0, 5'b00000, 1);
      send("jalr_misaligned", 3'd2, 3'b000, 5'd2, 32'h1001, 32'h0, 32'h0, 12'h002, 20'h0,
           32'h200, 32'h1002, 32'h0, 5'b10100, 1);
      send("jal_wrap", 3'd1, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 12'h000, 20'h2,
           32'hFFFF_FFFC, 32'h0, 32'h0, 5'b10000, 1);
      send("beq_back", 3'd3, 3'b000, 5'd0, 32'h5, 32'h5, 32'h0, 12'hFFC, 20'h0,
           32'h800, 32'h7F8, 32'h0, 5'b10000, 1);
      send("bgeu_half_tgt", 3'd3, 3'b111, 5'd0, 32'hFFFF_FFFF, 32'h1, 32'h0, 12'h001, 20'h0,
           32'hA00, 32'hA02, 32'h0, 5'b10100, 1);
      send("bge_not_taken", 3'd3, 3'b101, 5'd0, 32'hFFFF_FFFF, 32'h1, 32'h0, 12'h020, 20'h0,
           32'hB00, 32'hB04, 32'h0, 5'b00000, 1);
      send("bne_not_taken", 3'd3, 3'b001, 5'd0, 32'h7, 32'h7, 32'h0, 12'h020, 20'h0,
           32'hC00, 32'hC04, 32'h0, 5'b00000, 1);
      send("branch_ill", 3'd3, 3'b010, 5'd0, 32'h0, 32'h0, 32'h0, 12'h010, 20'h0,
           32'h600, 32'h604, 32'h0, 5'b00001, 1);
      send("csr_rc", 3'd6, 3'b011, 5'd5, 32'h0F, 32'h0, 32'hFF, 12'h0, 20'h0,
           32'h300, 32'h304, 32'hF0, 5'b01000, 1);
      send("csr_rsi_zero", 3'd6, 3'b110, 5'd0, 32'hFFFF, 32'h0, 32'h1234, 12'h0, 20'h0,
           32'h310, 32'h314, 32'h1234, 5'b00000, 1);
      send("csr_rwi", 3'd6, 3'b101, 5'h1F, 32'h0, 32'h0, 32'h55, 12'h0, 20'h0,
           32'h320, 32'h324, 32'h1F, 5'b01000, 1);
      send("csr_rw_x0", 3'd6, 3'b001, 5'd0, 32'hABCD, 32'h0, 32'h77, 12'h0, 20'h0,
           32'h340, 32'h344, 32'hABCD, 5'b01000, 1);
      send("csr_ill", 3'd6, 3'b000, 5'd3, 32'h5, 32'h0, 32'h9, 12'h0, 20'h0,
           32'h330, 32'h334, 32'h0, 5'b00001, 1);
      send("amo_mis", 3'd5, 3'b010, 5'd1, 32'h3002, 32'h0, 32'h0, 12'h0, 20'h0,
           32'h700, 32'h704, 32'h3002, 5'b00010, 1);
      send("mem_half_mis", 3'd4, 3'b001, 5'd1, 32'h11, 32'h0, 32'h0, 12'h000, 20'h0,
           32'h410, 32'h414, 32'h11, 5'b00010, 1);
      send("mem_byte", 3'd4, 3'b000, 5'd1, 32'h13, 32'h0, 32'h0, 12'h001, 20'h0,
           32'h430, 32'h434, 32'h14, 5'b00000, 1);
      send("mem_ill", 3'd4, 3'b011, 5'd1, 32'h20, 32'h0, 32'h0, 12'h004, 20'h0,
           32'h420, 32'h424, 32'h0, 5'b00001, 1);
      send("op_rsvd", 3'd7, 3'b000, 5'd0, 32'h1, 32'h2, 32'h3, 12'h0, 20'h0,
           32'h500, 32'h504, 32'h0, 5'b00001, 1);
      send("seq", 3'd0, 3'b000, 5'd0, 32'h1, 32'h2, 32'h3, 12'h0, 20'h0,
           32'h900, 32'h904, 32'h0, 5'b00000, 1);
      drain();

      // Back-pressure: result held for 5 cycles while a new op is offered and ignored.
      out_ready = 1'b0;
      send("mem_word_hold", 3'd4, 3'b010, 5'd1, 32'h2000, 32'h0, 32'h0, 12'hFFE, 20'h0,
           32'h400, 32'h404, 32'h1FFE, 5'b00010, 1);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (out_valid) break;
      end
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         op = 3'd0; pc = 32'hE00; in_valid = 1'b1;
         @(negedge clk);
         chk("hold_out_valid", W'(out_valid), W'(1));
         chk("hold_in_ready", W'(in_ready), W'(0));
         chk("hold_stable", obs, {32'h404, 32'h1FFE, 5'b00010});
      end
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b1;
      drain();

      // Flush while the op is in SUM: nothing is produced.
      send("flush_sum", 3'd1, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 12'h0, 20'h40,
           32'h2000, 32'h0, 32'h0, 5'b00000, 0);
      @(posedge clk); #1 flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      @(negedge clk);
      chk("flush_sum_out_valid", W'(out_valid), W'(0));
      chk("flush_sum_in_ready", W'(in_ready), W'(1));

      // Flush in HOLD with out_ready high: result dropped, outputs keep their values.
      send("flush_hold", 3'd1, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 12'h0, 20'h10,
           32'h1000, 32'h0, 32'h0, 5'b00000, 0);
      @(posedge clk);
      @(posedge clk); #1 flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      @(negedge clk);
      chk("flush_hold_out_valid", W'(out_valid), W'(0));
      chk("flush_hold_in_ready", W'(in_ready), W'(1));
      chk("flush_hold_pc_kept", W'(pc_next), W'(32'h1020));

      send("after_flush", 3'd0, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 12'h0, 20'h0,
           32'hD00, 32'hD04, 32'h0, 5'b00000, 1);
      drain();
      repeat (4) @(negedge clk);
      chk("queue_empty", W'(exp_q.size()), W'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
